// File: rtl/input_clock_monitor_pkg.sv
// Shared definitions for the input clock monitor: FSM encoding, nominal
// defaults for a 250 MHz monitored clock, and the window range test.
package input_clock_monitor_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } mon_state_e;

  // One transition of the divide-by-2 toggle per monitored clock cycle.
  localparam int unsigned DEF_GATE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_GATE_WIDTH  = 32'd20;
  localparam int unsigned DEF_COUNT_WIDTH = 32'd20;
  localparam int unsigned DEF_MIN_COUNT   = 32'd240000;
  localparam int unsigned DEF_MAX_COUNT   = 32'd260000;
  localparam int unsigned DEF_LOCK_GOOD   = 32'd4;
  localparam int unsigned DEF_SYNC_STAGES = 32'd2;

  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/input_clock_monitor_sync.sv
// Multi-flop synchronizer for a toggling heartbeat plus a history flop; the
// XOR of the two flags every transition in either direction.
module toggle_edge_sync
  import input_clock_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Next-state of the synchronizer chain and history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/input_clock_monitor.sv
// Qualifies the deskewed input clock by counting toggle transitions over a
// fixed gate window of the local clock and tracking lock / loss status.
module input_clock_monitor
  import input_clock_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned GATE_WIDTH  = DEF_GATE_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int unsigned MIN_COUNT   = DEF_MIN_COUNT,
  parameter int unsigned MAX_COUNT   = DEF_MAX_COUNT,
  parameter int unsigned LOCK_GOOD   = DEF_LOCK_GOOD,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   toggle_i,
  input  logic                   clear_i,
  output logic [COUNT_WIDTH-1:0] freq_o,
  output logic                   freq_valid_o,
  output logic                   clk_ok_o,
  output logic                   clk_lost_o
);

  localparam int unsigned GOOD_WIDTH = $clog2(LOCK_GOOD + 32'd1);
  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 32'd1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [GOOD_WIDTH-1:0]  GOOD_MAX  = GOOD_WIDTH'(LOCK_GOOD);

  logic edge_s;

  toggle_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_toggle_edge_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(toggle_i),
    .edge_o (edge_s)
  );

  mon_state_e             state_q, state_d;
  logic [GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [GOOD_WIDTH-1:0]  good_q, good_d;
  logic [COUNT_WIDTH-1:0] freq_q, freq_d;
  logic                   freq_valid_q, freq_valid_d;
  logic                   clk_ok_q, clk_ok_d;
  logic                   clk_lost_q, clk_lost_d;

  logic [COUNT_WIDTH-1:0] cnt_inc_s;
  logic [GOOD_WIDTH-1:0]  good_inc_s;
  logic                   terminal_s;
  logic                   in_range_s;
  logic                   lost_set_s;

  // Saturating edge count including this cycle's edge, and window qualification.
  always_comb begin
    cnt_inc_s = edge_cnt_q;
    if (edge_s && (edge_cnt_q != CNT_MAX)) begin
      cnt_inc_s = edge_cnt_q + COUNT_WIDTH'(1'b1);
    end else begin
      cnt_inc_s = edge_cnt_q;
    end
    good_inc_s = good_q;
    if (good_q == GOOD_MAX) begin
      good_inc_s = good_q;
    end else begin
      good_inc_s = good_q + GOOD_WIDTH'(1'b1);
    end
    terminal_s = (gate_q == GATE_LAST);
    in_range_s = in_window(32'(cnt_inc_s), MIN_COUNT, MAX_COUNT);
  end

  // Measurement FSM: gate/edge counting, window capture and lock tracking.
  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    edge_cnt_d   = edge_cnt_q;
    good_d       = good_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    clk_ok_d     = clk_ok_q;
    lost_set_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_d     = {GATE_WIDTH{1'b0}};
        edge_cnt_d = {COUNT_WIDTH{1'b0}};
        good_d     = {GOOD_WIDTH{1'b0}};
        clk_ok_d   = 1'b0;
        if (enable_i) begin
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (!enable_i) begin
          // Partial window is dropped; losing enable is not a clock loss.
          state_d    = ST_IDLE;
          gate_d     = {GATE_WIDTH{1'b0}};
          edge_cnt_d = {COUNT_WIDTH{1'b0}};
          good_d     = {GOOD_WIDTH{1'b0}};
          clk_ok_d   = 1'b0;
        end else if (terminal_s) begin
          gate_d       = {GATE_WIDTH{1'b0}};
          edge_cnt_d   = {COUNT_WIDTH{1'b0}};
          freq_d       = cnt_inc_s;
          freq_valid_d = 1'b1;
          if (in_range_s) begin
            good_d   = good_inc_s;
            clk_ok_d = (good_inc_s == GOOD_MAX);
          end else begin
            good_d     = {GOOD_WIDTH{1'b0}};
            clk_ok_d   = 1'b0;
            lost_set_s = clk_ok_q;
          end
        end else begin
          gate_d     = gate_q + GATE_WIDTH'(1'b1);
          edge_cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gate_d     = {GATE_WIDTH{1'b0}};
        edge_cnt_d = {COUNT_WIDTH{1'b0}};
        good_d     = {GOOD_WIDTH{1'b0}};
        clk_ok_d   = 1'b0;
      end
    endcase
  end

  // Sticky loss flag; a new loss event beats a simultaneous clear.
  always_comb begin
    clk_lost_d = clk_lost_q;
    if (lost_set_s) begin
      clk_lost_d = 1'b1;
    end else if (clear_i) begin
      clk_lost_d = 1'b0;
    end else begin
      clk_lost_d = clk_lost_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      gate_q       <= {GATE_WIDTH{1'b0}};
      edge_cnt_q   <= {COUNT_WIDTH{1'b0}};
      good_q       <= {GOOD_WIDTH{1'b0}};
      freq_q       <= {COUNT_WIDTH{1'b0}};
      freq_valid_q <= 1'b0;
      clk_ok_q     <= 1'b0;
      clk_lost_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      edge_cnt_q   <= edge_cnt_d;
      good_q       <= good_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      clk_ok_q     <= clk_ok_d;
      clk_lost_q   <= clk_lost_d;
    end
  end

  assign freq_o       = freq_q;
  assign freq_valid_o = freq_valid_q;
  assign clk_ok_o     = clk_ok_q;
  assign clk_lost_o   = clk_lost_q;

endmodule

// File: doc/input_clock_monitor.md
Name: input_clock_monitor

Overview:
- Sits directly downstream of the input clock deskew/buffer stage. It qualifies the buffered external clock before any logic uses it.
- The deskewed clock domain drives a divide-by-2 toggle flop. This block samples that toggle in the local system clock domain and counts its transitions over a fixed gate window. Each transition equals one monitored clock cycle.
- It reports the measured count, a qualified "clock OK" status, and a sticky "clock lost" flag for the housekeeping registers.

Parameters:
- GATE_CYCLES, 1000000: clk_i cycles per measurement window. Must be ≥ 2.
- GATE_WIDTH, 20: width of the gate counter. Must satisfy 2^GATE_WIDTH ≥ GATE_CYCLES.
- COUNT_WIDTH, 20: width of the edge counter and freq_o.
- MIN_COUNT, 240000: lowest in-range window count, inclusive.
- MAX_COUNT, 260000: highest in-range window count, inclusive.
- LOCK_GOOD, 4: consecutive in-range windows required before clk_ok_o asserts. Must be ≥ 1.
- SYNC_STAGES, 2: synchronizer depth on toggle_i. Must be ≥ 2.

Ports:
- clk_i  in  1  system clock; the only clock in this block.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  when low, monitoring is held idle.
- toggle_i  in  1  asynchronous toggle from the deskewed clock domain.
- clear_i  in  1  single-cycle pulse; clears clk_lost_o.
- freq_o  out  COUNT_WIDTH  edge count from the last completed window.
- freq_valid_o  out  1  one-cycle pulse when freq_o updates.
- clk_ok_o  out  1  monitored clock is qualified in range.
- clk_lost_o  out  1  sticky; monitored clock fell out of qualification.

Behaviour:
- Reset values (on rst_i high at a clk_i edge): freq_o=0, freq_valid_o=0, clk_ok_o=0, clk_lost_o=0. All internal state is also cleared: synchronizer flops, edge-detect history, gate counter, edge counter, good-run counter, FSM=IDLE.
- Synchronizer:
  - toggle_i passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_out XOR history, so both transition directions count.
  - Latency from a toggle_i transition to the counted edge is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE:
    - gate and edge counters are held at 0; good-run counter is 0; clk_ok_o=0; freq_o holds its last value.
    - IDLE→MEASURE when enable_i=1. The first MEASURE cycle is gate count 0.
  - MEASURE:
    - gate counter runs 0..GATE_CYCLES-1.
    - edge counter increments on each edge and saturates at 2^COUNT_WIDTH-1.
    - At gate count GATE_CYCLES-1 (the terminal cycle):
      - freq_o <= edge_cnt + edge, saturating. The edge in the terminal cycle belongs to the closing window.
      - freq_valid_o=1 on the following cycle, for exactly one cycle.
      - Edge and gate counters restart at 0 with no dead cycle.
    - MEASURE→IDLE when enable_i=0, checked every cycle. A partial window is discarded: no freq_valid_o pulse, freq_o unchanged, clk_ok_o drops the next cycle. clk_lost_o is not set by this transition.
- Qualification, evaluated on the captured window value:
  - in_range = (MIN_COUNT ≤ value ≤ MAX_COUNT).
  - In range: good-run counter increments, saturating at LOCK_GOOD. clk_ok_o=1 once good-run = LOCK_GOOD, updated in the same cycle as freq_o.
  - Out of range: good-run counter → 0 and clk_ok_o → 0 in that same cycle. If clk_ok_o was 1, clk_lost_o is set.
- clk_lost_o:
  - Set only on a 1→0 transition of clk_ok_o caused by an out-of-range window.
  - Cleared by clear_i.
  - If set and clear_i occur in the same cycle, set wins.
- A window count of 0 (monitored clock dead) is out of range whenever MIN_COUNT ≥ 1.
- enable_i toggling mid-window restarts the next window cleanly from gate count 0.
- rst_i asserted mid-window aborts the window. All outputs return to reset values the next cycle.

Decomposition:
- Shared package constants: the FSM state encoding (IDLE, MEASURE), and the default GATE_CYCLES/MIN_COUNT/MAX_COUNT for the 250 MHz nominal input against the local clock.
- One natural sub-module: toggle_edge_sync, containing the SYNC_STAGES synchronizer, the history flop and the XOR edge output. It is reusable for other cross-domain heartbeat signals.

Test Plan (bench parameters: GATE_CYCLES=100, MIN_COUNT=20, MAX_COUNT=30, LOCK_GOOD=3, SYNC_STAGES=2, COUNT_WIDTH=8):
- Nominal lock:
  - Stimulus: assert enable_i; toggle_i flips every 4 clk_i cycles, phase-aligned to the window start.
  - Response: freq_o=25 with a freq_valid_o pulse every 100 cycles; clk_ok_o rises on the 3rd window capture; clk_lost_o=0.
- Clock loss:
  - Stimulus: after lock, freeze toggle_i.
  - Response: the next complete window gives freq_o=0; clk_ok_o falls and clk_lost_o sets in the same cycle; clk_lost_o stays 1 after toggling resumes until a clear_i pulse.
- Out-of-range high and saturation:
  - Stimulus: toggle_i flips every clk_i cycle.
  - Response: freq_o=100, clk_ok_o never asserts, clk_lost_o stays 0.
  - Re-run with COUNT_WIDTH=6: freq_o saturates at 63.
- Enable drop mid-window:
  - Stimulus: deassert enable_i at gate count 50, then reassert.
  - Response: no freq_valid_o pulse; freq_o keeps its prior value; clk_ok_o=0 the next cycle; clk_lost_o=0; the next window's freq_valid_o arrives 100 cycles after re-entry into MEASURE.
- Set/clear collision and reset:
  - Stimulus: drive clear_i in the same cycle an out-of-range window drops clk_ok_o.
  - Response: clk_lost_o=1.
  - Then assert rst_i mid-window: all outputs read 0 the next cycle.
